// File: rtl/rom_inst_resp_pkg.sv
// Shared types and widths for the instruction-fetch ROM responder.
package rom_inst_resp_pkg;

    localparam int unsigned LINE_WORDS     = 4;
    localparam int unsigned WORD_BITS      = 32;
    localparam int unsigned LINE_BITS      = LINE_WORDS * WORD_BITS;
    localparam int unsigned PORT_ADDR_BITS = 24;
    localparam int unsigned WORD_IDX_BITS  = 2;
    localparam int unsigned WAIT_CNT_BITS  = 4;
    localparam int unsigned TOUT_CNT_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2,
        ST_TOUT = 2'd3
    } state_e;

    // True when the given word index is the final word of a line.
    function automatic logic is_last_word(input logic [WORD_IDX_BITS-1:0] idx);
        return idx == WORD_IDX_BITS'(LINE_WORDS - 1);
    endfunction

endpackage

// File: rtl/rom_line_asm.sv
// Cache-line assembler: shifts 32-bit ROM words into a 128-bit line, MSW first.
module rom_line_asm
    import rom_inst_resp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     capture_i,
    input  logic [WORD_BITS-1:0]     word_i,
    output logic [LINE_BITS-1:0]     line_o,
    output logic [WORD_IDX_BITS-1:0] word_idx_o,
    output logic                     last_word_o
);

    logic [LINE_BITS-1:0]     line_q, line_d;
    logic [WORD_IDX_BITS-1:0] idx_q, idx_d;

    // Line contents only move on capture so the last line is held otherwise.
    always_comb begin
        line_d = line_q;
        idx_d  = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (capture_i) begin
            line_d = {line_q[LINE_BITS-WORD_BITS-1:0], word_i};
            idx_d  = WORD_IDX_BITS'(idx_q + WORD_IDX_BITS'(1));
        end
    end

    // Line and word-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            idx_q  <= '0;
        end else begin
            line_q <= line_d;
            idx_q  <= idx_d;
        end
    end

    assign line_o      = line_q;
    assign word_idx_o  = idx_q;
    assign last_word_o = is_last_word(idx_q);

endmodule

// File: rtl/rom_inst_resp.sv
// Instruction-fetch ROM responder: reads a 128-bit line as four waited 32-bit
// ROM accesses and answers with a one-cycle ack, or a timeout for unmapped lines.
module rom_inst_resp
    import rom_inst_resp_pkg::*;
#(
    parameter int unsigned WAIT_STATES    = 3,
    parameter int unsigned ROM_LINE_BITS  = 11,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rom_inst_stb,
    input  logic [PORT_ADDR_BITS-1:0]  rom_inst_addr,
    output logic [LINE_BITS-1:0]       rom_inst_dout,
    output logic                       rom_inst_ack,
    output logic                       rom_inst_timeout,
    output logic                       rom_ce,
    output logic [ROM_LINE_BITS+1:0]   rom_addr,
    input  logic [WORD_BITS-1:0]       rom_data
);

    localparam int unsigned ROM_ADDR_BITS = ROM_LINE_BITS + 2;

    state_e state_q, state_d;

    logic [ROM_LINE_BITS-1:0] line_q, line_d;
    logic [WAIT_CNT_BITS-1:0] wcnt_q, wcnt_d;
    logic [TOUT_CNT_BITS-1:0] tcnt_q, tcnt_d;
    logic                     ce_q, ce_d;
    logic [ROM_ADDR_BITS-1:0] raddr_q, raddr_d;
    logic                     ack_q, ack_d;
    logic                     tout_q, tout_d;

    logic                     addr_mapped_c;
    logic                     word_done_c;
    logic                     tout_hit_c;
    logic                     asm_clear;
    logic                     asm_capture;
    logic [WORD_IDX_BITS-1:0] word_idx;
    logic                     last_word;

    // Request decode and counter terminal conditions.
    assign addr_mapped_c = (rom_inst_addr[PORT_ADDR_BITS-1:ROM_LINE_BITS] == '0);
    assign word_done_c   = (wcnt_q == WAIT_CNT_BITS'(WAIT_STATES));
    assign tout_hit_c    = (tcnt_q == TOUT_CNT_BITS'(TIMEOUT_CYCLES - 2));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE ignores stb so a held strobe cannot re-trigger.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rom_inst_stb) begin
                    state_d = addr_mapped_c ? ST_READ : ST_TOUT;
                end
            end
            ST_READ: begin
                if (word_done_c && last_word) begin
                    state_d = ST_DONE;
                end
            end
            ST_TOUT: begin
                if (tout_hit_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values: counters, ROM pins, response pulses.
    always_comb begin
        line_d      = line_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        ce_d        = ce_q;
        raddr_d     = raddr_q;
        ack_d       = 1'b0;
        tout_d      = 1'b0;
        asm_clear   = 1'b0;
        asm_capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ce_d = 1'b0;
                if (rom_inst_stb) begin
                    if (addr_mapped_c) begin
                        line_d    = rom_inst_addr[ROM_LINE_BITS-1:0];
                        wcnt_d    = '0;
                        ce_d      = 1'b1;
                        raddr_d   = {rom_inst_addr[ROM_LINE_BITS-1:0], WORD_IDX_BITS'(0)};
                        asm_clear = 1'b1;
                    end else begin
                        tcnt_d = '0;
                    end
                end
            end
            ST_READ: begin
                if (word_done_c) begin
                    asm_capture = 1'b1;
                    wcnt_d      = '0;
                    if (last_word) begin
                        ce_d  = 1'b0;
                        ack_d = 1'b1;
                    end else begin
                        raddr_d = {line_q, WORD_IDX_BITS'(word_idx + WORD_IDX_BITS'(1))};
                    end
                end else begin
                    wcnt_d = WAIT_CNT_BITS'(wcnt_q + WAIT_CNT_BITS'(1));
                end
            end
            ST_TOUT: begin
                ce_d = 1'b0;
                if (tout_hit_c) begin
                    tout_d = 1'b1;
                end else begin
                    tcnt_d = TOUT_CNT_BITS'(tcnt_q + TOUT_CNT_BITS'(1));
                end
            end
            ST_DONE: begin
                ce_d = 1'b0;
            end
            default: begin
                ce_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            ce_q    <= 1'b0;
            raddr_q <= '0;
            ack_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            line_q  <= line_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            ce_q    <= ce_d;
            raddr_q <= raddr_d;
            ack_q   <= ack_d;
            tout_q  <= tout_d;
        end
    end

    rom_line_asm u_line_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (asm_clear),
        .capture_i   (asm_capture),
        .word_i      (rom_data),
        .line_o      (rom_inst_dout),
        .word_idx_o  (word_idx),
        .last_word_o (last_word)
    );

    assign rom_ce           = ce_q;
    assign rom_addr         = raddr_q;
    assign rom_inst_ack     = ack_q;
    assign rom_inst_timeout = tout_q;

endmodule

// File: tb/tb_rom_inst_resp.sv
// Scoreboard bench for rom_inst_resp: a default-wait instance and a zero-wait instance.
module tb_rom_inst_resp;

    localparam int unsigned TO_CYC = 16;

    logic         clk;
    logic         rst_n;

    logic         stb0, stb1;
    logic [23:0]  addr0, addr1;
    logic [127:0] dout0, dout1;
    logic         ack0, ack1, to0, to1, ce0, ce1;
    logic [12:0]  raddr0, raddr1;
    logic [31:0]  rdata0, rdata1;

    int n_checks;
    int n_errors;
    logic [127:0] exp_q[$];

    rom_inst_resp #(.WAIT_STATES(3), .ROM_LINE_BITS(11), .TIMEOUT_CYCLES(TO_CYC)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rom_inst_stb(stb0), .rom_inst_addr(addr0),
        .rom_inst_dout(dout0), .rom_inst_ack(ack0), .rom_inst_timeout(to0),
        .rom_ce(ce0), .rom_addr(raddr0), .rom_data(rdata0));

    rom_inst_resp #(.WAIT_STATES(0), .ROM_LINE_BITS(11), .TIMEOUT_CYCLES(TO_CYC)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rom_inst_stb(stb1), .rom_inst_addr(addr1),
        .rom_inst_dout(dout1), .rom_inst_ack(ack1), .rom_inst_timeout(to1),
        .rom_ce(ce1), .rom_addr(raddr1), .rom_data(rdata1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: byte i holds i mod 256, big-endian within each word.
    function automatic logic [31:0] rom_word(input logic [12:0] wa);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(4 * int'(wa) + j);
        return w;
    endfunction

    function automatic logic [127:0] exp_line(input int ln);
        logic [127:0] v;
        for (int b = 0; b < 16; b++) v[127-8*b -: 8] = 8'(16 * ln + b);
        return v;
    endfunction

    always_comb rdata0 = rom_word(raddr0);
    always_comb rdata1 = rom_word(raddr1);

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [23:0] a);
        if (sel == 0) begin stb0 = s; addr0 = a; end
        else begin stb1 = s; addr1 = a; end
    endtask

    task automatic sample(input int sel, output logic ack, output logic to, output logic ce,
                          output logic [12:0] ra, output logic [127:0] d);
        if (sel == 0) begin ack = ack0; to = to0; ce = ce0; ra = raddr0; d = dout0; end
        else begin ack = ack1; to = to1; ce = ce1; ra = raddr1; d = dout1; end
    endtask

    // One request: push expectation, follow the ROM pins each cycle, pop on response.
    task automatic do_req(input int sel, input logic [23:0] a, input int ws, input bit is_to,
                          input int drop_k, input bit hold, input logic [127:0] exp_dout);
        int acc;
        bit done;
        bit ce_seen;
        logic ack, to, ce;
        logic [12:0] ra;
        logic [127:0] d;
        logic [127:0] e;
        acc = 4 * (ws + 1);
        done = 1'b0;
        ce_seen = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, a);
        exp_q.push_back(exp_dout);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            sample(sel, ack, to, ce, ra, d);
            if (ce) ce_seen = 1'b1;
            if (!is_to && k < acc) begin
                check_eq("rom_ce_window", 128'(ce), 128'(1));
                check_eq("rom_addr_step", 128'(ra), 128'({a[10:0], 2'(k / (ws + 1))}));
            end
            if (ack || to) begin
                done = 1'b1;
                check_eq(is_to ? "timeout_cycle" : "ack_cycle", 128'(k),
                         128'(is_to ? TO_CYC - 1 : acc - 1 + 1));
                check_eq("resp_kind_ack", 128'(ack), 128'(!is_to));
                check_eq("resp_kind_to", 128'(to), 128'(is_to));
                check_eq("rom_ce_at_resp", 128'(ce), 128'(0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("dout", d, e);
                end else begin
                    check_eq("scoreboard_empty", 128'(0), 128'(1));
                end
                break;
            end
            if (k == drop_k) begin
                @(negedge clk);
                drive(sel, 1'b0, 24'hFFFFFF);
            end
        end
        if (!done) begin
            check_eq("response_bound", 128'(0), 128'(1));
            void'(exp_q.pop_front());
        end
        if (!hold) begin
            @(negedge clk);
            drive(sel, 1'b0, a);
        end
        @(posedge clk);
        #1;
        sample(sel, ack, to, ce, ra, d);
        check_eq("resp_one_cycle", 128'(ack | to), 128'(0));
        check_eq("done_no_restart", 128'(ce), 128'(0));
        if (hold) begin
            @(negedge clk);
            drive(sel, 1'b0, a);
            @(posedge clk);
            #1;
            check_eq("idle_after_hold", 128'(sel == 0 ? ce0 : ce1), 128'(0));
        end
        if (is_to) check_eq("rom_ce_never_on_timeout", 128'(ce_seen), 128'(0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        stb0 = 1'b0; addr0 = '0;
        stb1 = 1'b0; addr1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", 128'(ack0), 128'(0));
        check_eq("rst_timeout", 128'(to0), 128'(0));
        check_eq("rst_rom_ce", 128'(ce0), 128'(0));
        check_eq("rst_rom_addr", 128'(raddr0), 128'(0));
        check_eq("rst_dout", dout0, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Default wait states: lines 0 and 5, held stb, unmapped line, dropped stb.
        do_req(0, 24'd0, 3, 1'b0, -1, 1'b0, 128'h000102030405060708090A0B0C0D0E0F);
        do_req(0, 24'd5, 3, 1'b0, -1, 1'b1, 128'h505152535455565758595A5B5C5D5E5F);
        do_req(0, 24'h000800, 3, 1'b1, -1, 1'b0, 128'h505152535455565758595A5B5C5D5E5F);
        do_req(0, 24'd3, 3, 1'b0, 2, 1'b0, 128'h303132333435363738393A3B3C3D3E3F);

        // Zero wait states: line 1, then lines 0..15 back to back.
        do_req(1, 24'd1, 0, 1'b0, -1, 1'b0, 128'h101112131415161718191A1B1C1D1E1F);
        for (int ln = 0; ln < 16; ln++) begin
            do_req(1, 24'(ln), 0, 1'b0, -1, 1'b0, exp_line(ln));
        end

        // Asynchronous reset in the middle of a line-2 read.
        @(negedge clk);
        drive(0, 1'b1, 24'd2);
        repeat (6) @(posedge clk);
        #1;
        check_eq("ce_before_reset", 128'(ce0), 128'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_ack", 128'(ack0), 128'(0));
        check_eq("async_rst_timeout", 128'(to0), 128'(0));
        check_eq("async_rst_rom_ce", 128'(ce0), 128'(0));
        check_eq("async_rst_dout", dout0, 128'(0));
        check_eq("async_rst_rom_addr", 128'(raddr0), 128'(0));
        @(negedge clk);
        drive(0, 1'b0, 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 24'd2, 3, 1'b0, -1, 1'b0, exp_line(2));

        check_eq("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_inst_resp.md
Name: rom_inst_resp

Overview:
Responder (slave) end of the instruction-fetch ROM port (stb/addr/dout/ack/timeout). It accepts a 128-bit cache-line read request from the fetch stage. It assembles the line from four sequential 32-bit accesses to an asynchronous ROM device, inserting programmable wait states per access. It answers with a one-cycle ack, or with a one-cycle timeout for addresses beyond the ROM size. It sits between the fetch stage's icache port and the board ROM pins.

Parameters:
WAIT_STATES, 3, extra clock cycles per 32-bit ROM access (access window = WAIT_STATES+1 cycles); legal range 0..15
ROM_LINE_BITS, 11, number of implemented line-address bits (2^11 lines = 32 KB)
TIMEOUT_CYCLES, 16, cycles from request acceptance to timeout pulse for unmapped lines; legal range 2..255

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
rom_inst_stb  in  1  request strobe from fetch stage; held high until ack or timeout
rom_inst_addr  in  24  line address (16-byte line index)
rom_inst_dout  out  128  assembled line; word at lowest address in [127:96] (big-endian)
rom_inst_ack  out  1  one-cycle pulse; rom_inst_dout valid in the same cycle
rom_inst_timeout  out  1  one-cycle pulse; request not serviced
rom_ce  out  1  ROM chip enable, high during each access window
rom_addr  out  ROM_LINE_BITS+2  ROM word address = {line, word_idx[1:0]}
rom_data  in  32  ROM read data, sampled on the last clock of each access window

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; rom_inst_ack=0, rom_inst_timeout=0, rom_ce=0, rom_addr=0, rom_inst_dout=0; word and wait counters=0.
- All outputs are registered.
- States: IDLE, READ, DONE, TOUT.
- IDLE:
  - stb=0: stay in IDLE.
  - stb=1 and addr[23:ROM_LINE_BITS]==0: latch the line, word_idx=0, wait counter=0, go to READ.
  - stb=1 and addr[23:ROM_LINE_BITS]!=0: timeout counter=0, go to TOUT.
- READ:
  - rom_ce=1; rom_addr={latched line, word_idx}.
  - Wait counter counts 0..WAIT_STATES.
  - At WAIT_STATES: rom_data shifts into the line register (first word ends in [127:96]), word_idx increments, wait counter clears.
  - After word 3 is captured: rom_ce drops, rom_inst_ack=1 for exactly one cycle, go to DONE.
- Latency: stb first sampled high in cycle 0 gives ack high in cycle 1+4*(WAIT_STATES+1) (cycle 17 with the defaults).
- DONE: one recovery cycle; stb is ignored, because the initiator may still hold stb in the ack cycle. Then return to IDLE. The minimum spacing between accepted requests is therefore 2 cycles after ack.
- TOUT:
  - Counter runs; rom_ce stays 0.
  - rom_inst_timeout pulses high in cycle TIMEOUT_CYCLES after acceptance; then DONE.
  - rom_inst_dout is unchanged.
- rom_inst_dout only changes on word capture. It holds the last line otherwise, including after timeout.
- stb dropped mid-READ (protocol violation): the line is completed and ack still pulses; no abort.
- rom_inst_addr changes mid-request are ignored (the line is latched at acceptance).
- ack and timeout are never high in the same cycle.
- Reset mid-operation: immediate return to reset values. No ack or timeout is issued for the interrupted request. The next request sees full latency.
- Width rules:
  - word_idx is 2 bits and wraps 3->0 only at line end.
  - Wait counter is 4 bits; timeout counter is 8 bits.

Decomposition:
- Shared package: state encodings (IDLE/READ/DONE/TOUT), LINE_WORDS=4, WORD_BITS=32, LINE_BITS=128, ROM port address width 24.
- One natural sub-module: rom_line_asm. It holds the 4x32 shift-in register plus word_idx, with capture and clear inputs, and outputs the 128-bit line and a last-word flag.
- FSM and counters stay in the top module.

Test Plan:
- ROM model byte i = i mod 256, defaults. Request line 0 -> rom_inst_dout=0x000102030405060708090A0B0C0D0E0F, ack high only in cycle 17, rom_addr steps 0,1,2,3 with 4 cycles each.
- Request line 5 -> dout=0x505152535455565758595A5B5C5D5E5F. Then hold stb high through the ack cycle -> no second request starts before the DONE cycle elapses.
- Request addr 0x000800 (first unmapped line) -> timeout in cycle 16 only, no ack, rom_ce never high, dout keeps the previous line.
- WAIT_STATES=0: line 1 -> dout=0x101112131415161718191A1B1C1D1E1F with ack in cycle 5. Sixteen back-to-back lines 0..15 read, each with correct contents.
- Pull rst_n low in cycle 6 of a line-2 read -> ack, timeout and rom_ce go to 0 asynchronously and dout is 0. Release and request line 2 -> correct line, ack at full latency.
- Drop stb in cycle 3 of a line-3 read -> ack still pulses in cycle 17 with dout=0x303132333435363738393A3B3C3D3E3F.
